// File: rtl/hex_scan_ctrl.sv
// Multiplexed 7-segment controller: holds host-written hex digits and scans them
// through a single shared decoder into per-digit active-low segment slots.
module hex_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned BLINK_SCANS = 50
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [2:0]              wr_idx,
    input  logic [3:0]              wr_data,
    output logic                    wr_err,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic                    frame_done,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [3:0]    NUM_D      = 4'(NUM_DIGITS);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [DW-1:0]   div_cnt;
    logic [BW-1:0]   scan_cnt;
    logic [2:0]      scan_idx;
    logic            blink_ph;
    logic [3:0]      digit [NUM_DIGITS];
    logic [6:0]      seg_q;
    logic            lz_q;

    logic [3:0]      cur_digit;
    logic            cur_blink;
    logic            lz_c;
    logic            wr_fire;
    logic            wr_bad;
    logic [6:0]      slot_val;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Next-state logic plus the scanned-digit selection shared by FETCH and COMMIT
    always_comb begin
        state_n   = state;
        cur_digit = 4'd0;
        cur_blink = 1'b0;
        lz_c      = (scan_idx != 3'd0);
        wr_fire   = wr_valid & wr_ready;
        wr_bad    = ({1'b0, wr_idx} >= NUM_D);

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == 3'(i)) begin
                cur_digit = digit[i];
                cur_blink = blink_mask[i];
            end
            if ((3'(i) >= scan_idx) && (digit[i] != 4'd0)) begin
                lz_c = 1'b0;
            end
        end

        if (cur_blink && blink_ph) begin
            slot_val = 7'b1111111;
        end else if (blank_lz && lz_q) begin
            slot_val = 7'b1111111;
        end else begin
            slot_val = seg_q;
        end

        case (state)
            IDLE:    if (div_cnt == DIV_LAST) state_n = FETCH;
            FETCH:   state_n = COMMIT;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath: digit storage, scan counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit[i] <= 4'd0;
            end
            hex_out    <= '1;
            div_cnt    <= '0;
            scan_idx   <= 3'd0;
            scan_cnt   <= '0;
            blink_ph   <= 1'b0;
            seg_q      <= 7'b1111111;
            lz_q       <= 1'b0;
            wr_ready   <= 1'b0;
            wr_err     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_ready   <= (state_n == IDLE);
            wr_err     <= wr_fire & wr_bad;
            frame_done <= 1'b0;

            if (wr_fire && !wr_bad) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (wr_idx == 3'(i)) digit[i] <= wr_data;
                end
            end

            case (state)
                IDLE: begin
                    div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
                end
                FETCH: begin
                    seg_q <= seg7(cur_digit);
                    lz_q  <= lz_c;
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (scan_idx == 3'(i)) hex_out[7*i +: 7] <= slot_val;
                    end
                    if (scan_idx == LAST_IDX) begin
                        scan_idx   <= 3'd0;
                        frame_done <= 1'b1;
                        if (scan_cnt == BLINK_LAST) begin
                            scan_cnt <= '0;
                            blink_ph <= ~blink_ph;
                        end else begin
                            scan_cnt <= scan_cnt + BW'(1);
                        end
                    end else begin
                        scan_idx <= scan_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: reference frames are queued as stimulus is applied and
// compared against hex_out at each frame_done pulse.
module tb_hex_scan_ctrl;

    localparam int unsigned ND        = 6;
    localparam int unsigned SD        = 4;
    localparam int unsigned BS        = 2;
    localparam int unsigned SCAN_CLKS = ND * (SD + 2);
    localparam logic [7*ND-1:0] ALL_BLANK = '1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [2:0]        wr_idx = 3'd0;
    logic [3:0]        wr_data = 4'd0;
    logic              wr_err;
    logic              blank_lz = 1'b0;
    logic [ND-1:0]     blink_mask = '0;
    logic              frame_done;
    logic [7*ND-1:0]   hex_out;

    int                n_vec = 0;
    int                n_err = 0;
    logic [3:0]        dig_m [ND];
    logic [7*ND-1:0]   exp_q [$];

    always #5 clk = ~clk;

    hex_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLINK_SCANS(BS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .blank_lz  (blank_lz),
        .blink_mask(blink_mask),
        .frame_done(frame_done),
        .hex_out   (hex_out)
    );

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[d];
    endfunction

    function automatic logic [7*ND-1:0] frame_ref(input logic blz, input logic [ND-1:0] mask,
                                                  input logic ph);
        logic [7*ND-1:0] f;
        logic            lead;
        f    = '0;
        lead = 1'b1;
        for (int i = ND - 1; i >= 0; i--) begin
            lead = lead && (dig_m[i] == 4'd0);
            if (mask[i] && ph)            f[7*i +: 7] = 7'h7F;
            else if (blz && lead && i != 0) f[7*i +: 7] = 7'h7F;
            else                          f[7*i +: 7] = seg_ref(dig_m[i]);
        end
        return f;
    endfunction

    task automatic apply_reset();
        reset_n    = 1'b0;
        wr_valid   = 1'b0;
        wr_idx     = 3'd0;
        wr_data    = 4'd0;
        blank_lz   = 1'b0;
        blink_mask = '0;
        for (int i = 0; i < ND; i++) dig_m[i] = 4'd0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_frame(output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        for (int n = 0; n < 4 * SCAN_CLKS; n++) begin
            @(negedge clk);
            cycles++;
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_timeout: no frame_done within %0d clk", 4 * SCAN_CLKS);
        end
    endtask

    task automatic check_frame(input string name, output int cycles);
        bit              ok;
        logic [7*ND-1:0] exp;
        wait_frame(cycles, ok);
        if (ok) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: frame seen %h but nothing expected", name, hex_out);
            end else begin
                exp = exp_q.pop_front();
                if (hex_out !== exp) begin
                    n_err++;
                    $display("FAIL %s: hex_out %h expected %h", name, hex_out, exp);
                end
            end
        end
    endtask

    task automatic do_write(input logic [2:0] idx, input logic [3:0] data);
        bit ok;
        ok       = 1'b0;
        wr_valid = 1'b1;
        wr_idx   = idx;
        wr_data  = data;
        for (int n = 0; n < 4 * (SD + 2); n++) begin
            @(negedge clk);
            if (wr_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            if (int'(idx) < ND) dig_m[idx] = data;
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL write_timeout: wr_ready never 1 for idx %0d", idx);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (hex_out !== ALL_BLANK) begin
            n_err++; $display("FAIL reset_hex: got %h expected %h", hex_out, ALL_BLANK);
        end
        n_vec++;
        if (wr_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready: got %b expected 0", wr_ready);
        end
        n_vec++;
        if ({frame_done, wr_err} !== 2'b00) begin
            n_err++; $display("FAIL reset_pulses: got %b expected 00", {frame_done, wr_err});
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (wr_ready !== 1'b1) begin
            n_err++; $display("FAIL ready_after_reset: got %b expected 1", wr_ready);
        end
    endtask

    task automatic test_single_digit();
        int cycles;
        bit ok;
        apply_reset();
        do_write(3'd2, 4'h5);
        wait_frame(cycles, ok);
        exp_q.push_back(frame_ref(1'b0, '0, 1'b0));
        check_frame("digit2_is_5", cycles);
        n_vec++;
        if (hex_out[20:14] !== 7'b0010010) begin
            n_err++; $display("FAIL slot2_seg5: got %b expected 0010010", hex_out[20:14]);
        end
        n_vec++;
        if (cycles != SCAN_CLKS) begin
            n_err++; $display("FAIL frame_period: got %0d expected %0d", cycles, SCAN_CLKS);
        end
        @(negedge clk);
        n_vec++;
        if (frame_done !== 1'b0) begin
            n_err++; $display("FAIL frame_pulse_width: got %b expected 0", frame_done);
        end
    endtask

    task automatic test_leading_zero();
        int cycles;
        bit ok;
        apply_reset();
        blank_lz = 1'b1;
        do_write(3'd0, 4'h3);
        do_write(3'd1, 4'h2);
        do_write(3'd2, 4'h1);
        wait_frame(cycles, ok);
        exp_q.push_back(frame_ref(1'b1, '0, 1'b0));
        check_frame("lz_123", cycles);
        n_vec++;
        if ({hex_out[41:21], hex_out[20:14]} !== {21'h1FFFFF, 7'b1111001}) begin
            n_err++;
            $display("FAIL lz_top_slots: got %h expected %h", hex_out[41:14], {21'h1FFFFF, 7'b1111001});
        end
        for (int i = 0; i < 3; i++) do_write(3'(i), 4'h0);
        do_write(3'd3, 4'h1);
        wait_frame(cycles, ok);
        exp_q.push_back(frame_ref(1'b1, '0, 1'b0));
        check_frame("lz_inner_zeros", cycles);
        do_write(3'd3, 4'h0);
        wait_frame(cycles, ok);
        exp_q.push_back(frame_ref(1'b1, '0, 1'b0));
        check_frame("lz_all_zero", cycles);
        n_vec++;
        if (hex_out !== {{35{1'b1}}, 7'b1000000}) begin
            n_err++; $display("FAIL lz_digit0_kept: got %h expected %h", hex_out, {{35{1'b1}}, 7'b1000000});
        end
    endtask

    task automatic test_blink();
        int cycles;
        apply_reset();
        blink_mask = 6'b000001;
        do_write(3'd0, 4'h7);
        do_write(3'd4, 4'hC);
        for (int k = 0; k < 6; k++) exp_q.push_back(frame_ref(1'b0, blink_mask, 1'((k / BS) % 2)));
        for (int k = 0; k < 6; k++) check_frame("blink_scan", cycles);
    endtask

    task automatic test_wr_err();
        int cycles;
        bit ok;
        apply_reset();
        do_write(3'd1, 4'h4);
        wait_frame(cycles, ok);
        do_write(3'd7, 4'hF);
        @(negedge clk);
        n_vec++;
        if (wr_err !== 1'b1) begin
            n_err++; $display("FAIL wr_err_pulse: got %b expected 1", wr_err);
        end
        @(negedge clk);
        n_vec++;
        if (wr_err !== 1'b0) begin
            n_err++; $display("FAIL wr_err_width: got %b expected 0", wr_err);
        end
        ok = 1'b0;
        for (int n = 0; n < 4 * (SD + 2); n++) begin
            if (wr_ready === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        wr_valid = 1'b1;
        wr_idx   = 3'd3;
        wr_data  = 4'h9;
        @(negedge clk);
        n_vec++;
        if (!ok || wr_ready !== 1'b0) begin
            n_err++; $display("FAIL ready_in_commit: got %b expected 0", wr_ready);
        end
        @(negedge clk);
        n_vec++;
        if (wr_ready !== 1'b1) begin
            n_err++; $display("FAIL ready_back_idle: got %b expected 1", wr_ready);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        dig_m[3] = 4'h9;
        @(negedge clk);
        n_vec++;
        if (wr_err !== 1'b0) begin
            n_err++; $display("FAIL wr_err_good_write: got %b expected 0", wr_err);
        end
        wait_frame(cycles, ok);
        exp_q.push_back(frame_ref(1'b0, '0, 1'b0));
        check_frame("after_bad_write", cycles);
    endtask

    task automatic test_reset_mid_commit();
        int  cycles;
        bit  ok;
        apply_reset();
        do_write(3'd0, 4'h8);
        wait_frame(cycles, ok);
        repeat (23) @(negedge clk);
        n_vec++;
        if (wr_ready !== 1'b0 || hex_out === ALL_BLANK) begin
            n_err++; $display("FAIL pre_reset_commit: ready %b hex %h expected ready 0 and lit", wr_ready, hex_out);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({hex_out, wr_ready, frame_done, wr_err} !== {ALL_BLANK, 3'b000}) begin
            n_err++;
            $display("FAIL async_reset: got %h expected %h", {hex_out, wr_ready, frame_done, wr_err}, {ALL_BLANK, 3'b000});
        end
        for (int i = 0; i < ND; i++) dig_m[i] = 4'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cycles  = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            cycles++;
            if (hex_out !== ALL_BLANK) break;
        end
        n_vec++;
        if (cycles != SD + 2 || hex_out !== {{35{1'b1}}, seg_ref(4'h0)}) begin
            n_err++;
            $display("FAIL restart_slot0: after %0d clk hex %h expected after %0d clk hex %h",
                     cycles, hex_out, SD + 2, {{35{1'b1}}, seg_ref(4'h0)});
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_leading_zero();
        test_blink();
        test_wr_err();
        test_reset_mid_commit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
